ifid_pipe_stage: RTL and testbench

Parametrised IF→ID pipeline stage with a valid/ready handshake, replacing the fixed 32-bit stall-driven IF/ID register. Carries PC, PC+4, instruction word and fetch-address exception flag from fetch to decode. Supports optional 2-entry skid buffering so upstream ready is registered, synchronous flush with NOP injection, and an occupancy count. Sits between the fetch unit (or I-cache response path) and the decoder.

---
 rtl/ifid_pipe_stage.sv | 189 ++++++++++++++++++
 tb/tb_ifid_pipe_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_pipe_stage.sv
// ifid_pipe_stage: IF->ID pipeline stage with valid/ready handshake.
// Carries PC, PC+4, instruction and fetch-address exception flag to decode.
// Optional macro IFID_SKID_EN adds a second (skid) slot so in_ready is a
// register output; without it the stage is a single slot with a
// combinational in_ready.
//
// Handshake: a beat moves on a port exactly when its valid and ready are
// both high at a rising clock edge; valid never waits on ready, and the
// data of a port is only meaningful while its valid is high.
module ifid_pipe_stage #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h00000033)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_add4,
  input  logic [ILEN-1:0] in_inst,
  input  logic            in_exc_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_add4,
  output logic [ILEN-1:0] out_inst,
  output logic            out_exc_addr,
  output logic [1:0]      count
);

  // State encoding equals the number of held entries, so count is the
  // state register itself and doubles as the FSM debug view.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1
`ifdef IFID_SKID_EN
    , S_TWO = 2'd2
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_main;
  logic            w_skid_to_main;

  logic [XLEN-1:0] r_main_pc;
  logic [XLEN-1:0] r_main_pc_add4;
  logic [ILEN-1:0] r_main_inst;
  logic            r_main_exc;

`ifdef IFID_SKID_EN
  logic            w_load_skid;
  logic            r_in_ready;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_pc_add4;
  logic [ILEN-1:0] r_skid_inst;
  logic            r_skid_exc;

  assign in_ready = r_in_ready;
`else
  // Single slot: room exists if empty or the held beat leaves this cycle.
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_valid  = (r_state != S_EMPTY);
  assign count      = r_state;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Next-state and slot-load decisions; flush overrides every transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_skid_to_main = 1'b0;
`ifdef IFID_SKID_EN
    w_load_skid    = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_load_main = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
`ifdef IFID_SKID_EN
          else if (w_in_fire) begin
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end
`endif
        end
`ifdef IFID_SKID_EN
        S_TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (w_out_fire) begin
            w_state_nxt    = S_ONE;
            w_skid_to_main = 1'b1;
          end
        end
`endif
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register; reset empties the stage without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main slot: loaded from upstream or refilled from the skid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_pc      <= '0;
      r_main_pc_add4 <= '0;
      r_main_inst    <= NOP_INST;
      r_main_exc     <= 1'b0;
    end else if (w_load_main) begin
      r_main_pc      <= in_pc;
      r_main_pc_add4 <= in_pc_add4;
      r_main_inst    <= in_inst;
      r_main_exc     <= in_exc_addr;
    end else if (w_skid_to_main) begin
`ifdef IFID_SKID_EN
      r_main_pc      <= r_skid_pc;
      r_main_pc_add4 <= r_skid_pc_add4;
      r_main_inst    <= r_skid_inst;
      r_main_exc     <= r_skid_exc;
`endif
    end
  end

`ifdef IFID_SKID_EN
  // Skid slot catches the beat accepted while the main slot is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_pc      <= '0;
      r_skid_pc_add4 <= '0;
      r_skid_inst    <= NOP_INST;
      r_skid_exc     <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_pc      <= in_pc;
      r_skid_pc_add4 <= in_pc_add4;
      r_skid_inst    <= in_inst;
      r_skid_exc     <= in_exc_addr;
    end
  end

  // Registered in_ready: accept next cycle only if the stage will not be full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end
`endif

  // Empty stage presents a NOP with no exception; PCs keep their last value.
  always_comb begin
    out_pc       = r_main_pc;
    out_pc_add4  = r_main_pc_add4;
    out_inst     = NOP_INST;
    out_exc_addr = 1'b0;
    if (out_valid) begin
      out_inst     = r_main_inst;
      out_exc_addr = r_main_exc;
    end
  end

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Bench for ifid_pipe_stage: FIFO-queue model of the stage checked every
// cycle, plus literal expectations at key points. Works in both builds
// (IFID_SKID_EN defined or not).
module tb_ifid_pipe_stage;
  localparam int              XLEN = 32;
  localparam int              ILEN = 32;
  localparam logic [ILEN-1:0] NOP  = 32'h00000033;
  localparam int              BW   = 2 * XLEN + ILEN + 1;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc_add4;
  logic [ILEN-1:0] in_inst;
  logic            in_exc_addr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_add4;
  logic [ILEN-1:0] out_inst;
  logic            out_exc_addr;
  logic [1:0]      count;

  ifid_pipe_stage #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_add4(in_pc_add4), .in_inst(in_inst),
    .in_exc_addr(in_exc_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_add4(out_pc_add4), .out_inst(out_inst),
    .out_exc_addr(out_exc_addr), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Queue of beats held by the stage, oldest first: {pc, pc_add4, inst, exc}.
  logic [BW-1:0]   exp_q[$];
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] last_pc4;

  function automatic logic model_in_ready();
`ifdef IFID_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin : model_blk
    logic in_fire;
    logic out_fire;
    if (rst) begin
      exp_q.delete();
      last_pc  = '0;
      last_pc4 = '0;
    end else begin
      in_fire  = in_valid && model_in_ready();
      out_fire = (exp_q.size() != 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire)  exp_q.push_back({in_pc, in_pc_add4, in_inst, in_exc_addr});
      end
      if (exp_q.size() != 0) begin
        last_pc  = exp_q[0][BW-1 -: XLEN];
        last_pc4 = exp_q[0][BW-1-XLEN -: XLEN];
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin : cmp_blk
    logic [BW-1:0] h;
    logic          v;
    if (!rst) begin
      v = (exp_q.size() != 0);
      h = v ? exp_q[0] : '0;
      check("out_valid", 64'(out_valid), 64'(v));
      check("count", 64'(count), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(model_in_ready()));
      check("out_pc", 64'(out_pc), 64'(v ? h[BW-1 -: XLEN] : last_pc));
      check("out_pc_add4", 64'(out_pc_add4), 64'(v ? h[BW-1-XLEN -: XLEN] : last_pc4));
      check("out_inst", 64'(out_inst), 64'(v ? h[ILEN:1] : NOP));
      check("out_exc_addr", 64'(out_exc_addr), 64'(v ? h[0] : 1'b0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic exc,
                       input logic ordy, input logic fl);
    in_valid    = v;
    in_pc       = pc;
    in_pc_add4  = pc + 32'd4;
    in_inst     = pc ^ 32'hC0DE_0013;
    in_exc_addr = exc;
    out_ready   = ordy;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'h33);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Streaming at full rate
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0); tick();
    check("stream_pc0", 64'(out_pc), 64'h100);
    check("stream_cnt0", 64'(count), 64'd1);
    drive(1'b1, 32'h104, 1'b0, 1'b1, 1'b0); tick();
    check("stream_pc1", 64'(out_pc), 64'h104);
    drive(1'b1, 32'h108, 1'b0, 1'b1, 1'b0); tick();
    check("stream_pc2", 64'(out_pc), 64'h108);
    check("stream_cnt2", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    check("stream_empty_inst", 64'(out_inst), 64'h33);
    check("stream_hold_pc", 64'(out_pc), 64'h108);

    // Exception flag passthrough
    drive(1'b1, 32'h402, 1'b1, 1'b1, 1'b0); tick();
    check("exc_flag1", 64'(out_exc_addr), 64'd1);
    check("exc_pc", 64'(out_pc), 64'h402);
    drive(1'b1, 32'h406, 1'b0, 1'b1, 1'b0); tick();
    check("exc_flag0", 64'(out_exc_addr), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();

    // Backpressure
`ifdef IFID_SKID_EN
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0); tick();
    check("bp_count2", 64'(count), 64'd2);
    check("bp_in_ready0", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0); tick();
    check("bp_hold_pc", 64'(out_pc), 64'h200);
    check("bp_hold_cnt", 64'(count), 64'd2);
    drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0); tick();
    check("bp_drain_pc1", 64'(out_pc), 64'h204);
    check("bp_drain_rdy", 64'(in_ready), 64'd1);
    tick();
    check("bp_drain_pc2", 64'(out_pc), 64'h208);
    check("bp_drain_cnt", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    check("bp_done_cnt", 64'(count), 64'd0);
`else
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0); tick();
    check("ns_cnt1", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); #1;
    check("ns_in_ready0", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h204, 1'b0, 1'b1, 1'b0); #1;
    check("ns_in_ready1", 64'(in_ready), 64'd1);
    tick();
    check("ns_swap_cnt", 64'(count), 64'd1);
    check("ns_swap_pc", 64'(out_pc), 64'h204);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
`endif

    // Flush while full (skid: two entries), input beat present
    drive(1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0); tick();
`ifdef IFID_SKID_EN
    drive(1'b1, 32'h2F4, 1'b0, 1'b0, 1'b0); tick();
    check("fl_pre_cnt", 64'(count), 64'd2);
`endif
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1); tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_inst", 64'(out_inst), 64'h33);
    check("fl_count", 64'(count), 64'd0);
    // Flush while a beat is handshaked in the same cycle
    drive(1'b1, 32'h2F8, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h304, 1'b0, 1'b1, 1'b1); tick();
    check("fl2_valid", 64'(out_valid), 64'd0);
    check("fl2_count", 64'(count), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); repeat (3) tick();

    // Mixed pattern table
    for (int i = 0; i < 24; i++) begin
      drive(((i % 3) != 2), 32'h500 + 32'(4 * i), ((i % 5) == 0),
            ((i % 4) != 1), (i == 17));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); repeat (3) tick();

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_inst", 64'(out_inst), 64'h33);
    check("arst_out_pc", 64'(out_pc), 64'd0);
    check("arst_out_pc4", 64'(out_pc_add4), 64'd0);
    check("arst_exc", 64'(out_exc_addr), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0); tick();
    check("post_rst_pc", 64'(out_pc), 64'h700);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
